// File: rtl/kong_ctrl.sv
// Kong sequencing controller: arbitrates left/right between the player and auto-patrol,
// and runs the barrel throw sequence (wind-up lock, spawn pulse, cooldown).
module kong_ctrl #(
  parameter int WINDUP_FRAMES     = 30,
  parameter int COOLDOWN_FRAMES   = 90,
  parameter int AUTO_THROW_FRAMES = 120,
  parameter int AUTO_XMIN         = 16,
  parameter int AUTO_XMAX         = 560
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_en,
  input  logic        frame_tick,
  input  logic        auto_mode,
  input  logic        p_left,
  input  logic        p_right,
  input  logic        p_throw,
  input  logic [10:0] kong_xpos,
  output logic        left,
  output logic        right,
  output logic        animation,
  output logic        barrel_spawn,
  output logic        throw_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_WINDUP, ST_COOLDOWN} state_t;

  localparam logic [7:0]  WIN_LAST  = 8'(WINDUP_FRAMES - 1);
  localparam logic [7:0]  COOL_LAST = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [7:0]  AUTO_LAST = 8'(AUTO_THROW_FRAMES - 1);
  localparam logic [10:0] XMIN      = 11'(AUTO_XMIN);
  localparam logic [10:0] XMAX      = 11'(AUTO_XMAX);

  state_t     state_q;
  logic [7:0] frame_cnt_q, auto_cnt_q;
  logic       thr_q, dir_q;
  logic       dir_d, auto_req, throw_req, mv_l, mv_r;

  always_comb begin
    auto_req  = game_en & auto_mode & frame_tick & (auto_cnt_q == AUTO_LAST);
    throw_req = (p_throw & ~thr_q) | auto_req;
    dir_d     = dir_q;
    // dir_q=1 means patrol heading right
    if (auto_mode) begin
      if (kong_xpos >= XMAX)      dir_d = 1'b0;
      else if (kong_xpos <= XMIN) dir_d = 1'b1;
    end
    mv_l = auto_mode ? ~dir_d : (p_left & ~p_right);
    mv_r = auto_mode ?  dir_d : (p_right & ~p_left);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= '0;
      auto_cnt_q   <= '0;
      thr_q        <= 1'b0;
      dir_q        <= 1'b1;
      left         <= 1'b0;
      right        <= 1'b0;
      animation    <= 1'b0;
      barrel_spawn <= 1'b0;
      throw_busy   <= 1'b0;
    end else begin
      thr_q        <= p_throw;
      left         <= 1'b0;
      right        <= 1'b0;
      animation    <= 1'b0;
      barrel_spawn <= 1'b0;
      throw_busy   <= 1'b0;
      if (!game_en) begin
        state_q     <= ST_IDLE;
        frame_cnt_q <= '0;
        auto_cnt_q  <= '0;
      end else begin
        dir_q <= dir_d;
        if (!auto_mode)      auto_cnt_q <= '0;
        else if (frame_tick) auto_cnt_q <= (auto_cnt_q == AUTO_LAST) ? 8'd0 : auto_cnt_q + 8'd1;
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_ACTIVE;
            left    <= mv_l;
            right   <= mv_r;
          end
          ST_ACTIVE: begin
            if (throw_req) begin
              state_q     <= ST_WINDUP;
              frame_cnt_q <= '0;
              animation   <= 1'b1;
              throw_busy  <= 1'b1;
            end else begin
              left  <= mv_l;
              right <= mv_r;
            end
          end
          ST_WINDUP: begin
            throw_busy <= 1'b1;
            if (frame_tick && frame_cnt_q == WIN_LAST) begin
              state_q      <= ST_COOLDOWN;
              frame_cnt_q  <= '0;
              barrel_spawn <= 1'b1;
              left         <= mv_l;
              right        <= mv_r;
            end else begin
              animation <= 1'b1;
              if (frame_tick) frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
          default: begin
            // cooldown: movement allowed, throw requests simply ignored
            left       <= mv_l;
            right      <= mv_r;
            throw_busy <= 1'b1;
            if (frame_tick) begin
              if (frame_cnt_q == COOL_LAST) begin
                state_q     <= ST_ACTIVE;
                frame_cnt_q <= '0;
                throw_busy  <= 1'b0;
              end else begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kong_ctrl.sv
// Directed table-driven bench for kong_ctrl (WINDUP=2, COOLDOWN=3, AUTO_THROW=4).
module tb_kong_ctrl;

  logic        clk, rst, game_en, frame_tick, auto_mode, p_left, p_right, p_throw;
  logic [10:0] kong_xpos;
  logic        left, right, animation, barrel_spawn, throw_busy;

  int total = 0;
  int bad   = 0;

  kong_ctrl #(
    .WINDUP_FRAMES(2), .COOLDOWN_FRAMES(3), .AUTO_THROW_FRAMES(4),
    .AUTO_XMIN(16), .AUTO_XMAX(560)
  ) dut (
    .clk(clk), .rst(rst), .game_en(game_en), .frame_tick(frame_tick),
    .auto_mode(auto_mode), .p_left(p_left), .p_right(p_right), .p_throw(p_throw),
    .kong_xpos(kong_xpos), .left(left), .right(right), .animation(animation),
    .barrel_spawn(barrel_spawn), .throw_busy(throw_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp = {left, right, animation, barrel_spawn, throw_busy}
  typedef struct {
    logic        en, tk, au, pl, pr, pt;
    logic [10:0] x;
    logic [4:0]  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, tk, au, pl, pr, pt,
                              input int x, input logic [4:0] e);
    vec_t v;
    v.en = en; v.tk = tk; v.au = au; v.pl = pl; v.pr = pr; v.pt = pt;
    v.x = 11'(x); v.exp = e;
    return v;
  endfunction

  function automatic logic [4:0] outs();
    return {left, right, animation, barrel_spawn, throw_busy};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (L R A S B)", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    game_en = v.en; frame_tick = v.tk; auto_mode = v.au;
    p_left = v.pl; p_right = v.pr; p_throw = v.pt; kong_xpos = v.x;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int spawns;
    //              en tk au pl pr pt  x     L R A S B
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 300, 5'b00000)); //  1 idle->active
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 300, 5'b10000)); //  2 left
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 300, 5'b00000)); //  3 both -> none
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 300, 5'b01000)); //  4 right
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 300, 5'b00101)); //  5 throw edge, left held
    vecs.push_back(mk(1, 1, 0, 1, 0, 1, 300, 5'b00101)); //  6 windup tick 1
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 300, 5'b00101)); //  7
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 300, 5'b10011)); //  8 tick 2 -> spawn
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 300, 5'b10001)); //  9 edge in cooldown dropped
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 300, 5'b00001)); // 10 cd tick 1
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 300, 5'b00001)); // 11 cd tick 2
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 300, 5'b00001)); // 12 edge dropped
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 300, 5'b00000)); // 13 cd tick 3 -> active
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 300, 5'b00000)); // 14
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 300, 5'b00101)); // 15 new throw accepted
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 300, 5'b00101)); // 16 held
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 300, 5'b00011)); // 17 spawn
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 300, 5'b00001)); // 18
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 300, 5'b00001)); // 19
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 300, 5'b00000)); // 20 active again
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 300, 5'b00000)); // 21 held: no repeat
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 300, 5'b00000)); // 22
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 300, 5'b00000)); // 23
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 300, 5'b01000)); // 24 patrol right
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 560, 5'b10000)); // 25 xmax -> left
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 300, 5'b10000)); // 26 direction holds
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  16, 5'b01000)); // 27 xmin -> right
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 300, 5'b01000)); // 28 player ignored
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 300, 5'b01000)); // 29 auto cnt 1
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 300, 5'b01000)); // 30 auto cnt 2
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 300, 5'b01000)); // 31 auto cnt 3
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 300, 5'b00101)); // 32 auto throw
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 300, 5'b00101)); // 33
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 300, 5'b01011)); // 34 spawn
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 300, 5'b01001)); // 35
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 300, 5'b01001)); // 36 auto req dropped
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 300, 5'b01000)); // 37 active
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 300, 5'b01000)); // 38
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 300, 5'b01000)); // 39
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 300, 5'b00101)); // 40 next auto throw
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 300, 5'b00101)); // 41 windup tick 1
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 300, 5'b00000)); // 42 abort, no spawn
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 300, 5'b00000)); // 43
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 300, 5'b00000)); // 44 restart
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 300, 5'b00101)); // 45 throw
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 300, 5'b00101)); // 46 counter restarted
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 300, 5'b00011)); // 47 spawn
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 300, 5'b00001)); // 48
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 300, 5'b00001)); // 49
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 300, 5'b00000)); // 50 active
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 300, 5'b00000)); // 51 throw + en low
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 300, 5'b00000)); // 52 idle->active
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 300, 5'b00000)); // 53 no windup

    // reset held with random inputs
    rst = 1'b0;
    drive(mk(1, 0, 0, 0, 0, 0, 300, 5'b0));
    for (int i = 0; i < 4; i++) begin
      game_en = 1'($urandom); frame_tick = 1'($urandom); auto_mode = 1'($urandom);
      p_left = 1'($urandom); p_right = 1'($urandom); p_throw = 1'($urandom);
      kong_xpos = 11'($urandom_range(0, 2047));
      step();
      check($sformatf("reset_hold_%0d", i), outs(), 5'b00000);
    end
    drive(mk(1, 0, 0, 0, 0, 0, 300, 5'b0));
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      step();
      check($sformatf("vec_%0d", i + 1), outs(), vecs[i].exp);
    end

    // throw held for 10 frames: exactly one spawn
    drive(mk(1, 0, 0, 0, 0, 0, 300, 5'b0));
    step();
    spawns = 0;
    p_throw = 1'b1; frame_tick = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      if (barrel_spawn) spawns++;
    end
    check("held_throw_spawns", 5'(spawns), 5'd1);

    // async reset in the middle of a windup
    drive(mk(1, 0, 0, 0, 0, 0, 300, 5'b0));
    step();
    p_throw = 1'b1;
    step();
    check("windup_before_reset", outs(), 5'b00101);
    #2 rst = 1'b0;
    #1 check("async_reset", outs(), 5'b00000);
    step();
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kong_ctrl.md
Name: kong_ctrl

Overview:
Sequencing controller placed in front of the Kong movement block. It arbitrates Kong's left/right commands between the remote player (UART-decoded buttons) and a built-in auto-patrol generator. It also schedules barrel throws: wind-up animation, a one-cycle spawn pulse to the barrel generator, then a cooldown. During wind-up it drives the movement block's animation lock and holds left/right low.

Parameters:
WINDUP_FRAMES, 30, frames the animation lock is held before the barrel is released (>=1)
COOLDOWN_FRAMES, 90, frames after release during which new throw requests are dropped (>=1)
AUTO_THROW_FRAMES, 120, frame period of automatic throw requests in auto mode (>=1)
AUTO_XMIN, 16, left patrol turn-around x position
AUTO_XMAX, 560, right patrol turn-around x position (> AUTO_XMIN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
game_en  in  1  game running; low forces the idle state
frame_tick  in  1  single-cycle pulse once per video frame
auto_mode  in  1  1 = auto-patrol/auto-throw, 0 = remote player inputs
p_left  in  1  player left button (level)
p_right  in  1  player right button (level)
p_throw  in  1  player throw button (level)
kong_xpos  in  11  current Kong x position, fed back from the movement block
left  out  1  move-left command to the movement block
right  out  1  move-right command to the movement block
animation  out  1  throw animation lock
barrel_spawn  out  1  one-cycle barrel release pulse
throw_busy  out  1  high in ST_WINDUP and ST_COOLDOWN

Behaviour:
- Reset (rst=0, asynchronous): state=ST_IDLE. All outputs 0. Frame counter, auto-throw counter and p_throw edge register cleared. Patrol direction=right.
- All outputs are registered. A decision made from inputs in cycle N is visible at the outputs in cycle N+1.
- game_en=0 in any state: the next state is ST_IDLE, all outputs go to 0 and all counters clear. An in-progress throw is aborted and no spawn pulse is produced.
- States: ST_IDLE, ST_ACTIVE, ST_WINDUP, ST_COOLDOWN.
- ST_IDLE -> ST_ACTIVE when game_en=1.
- ST_ACTIVE -> ST_WINDUP on a throw request (defined below).
- ST_WINDUP: animation=1 and left=right=0. The frame counter increments on each frame_tick. On the frame_tick where counter==WINDUP_FRAMES-1: barrel_spawn=1 for exactly one cycle, the counter clears, and the state goes to ST_COOLDOWN.
- ST_COOLDOWN: animation=0 and movement is allowed. Throw requests are dropped, not queued. On the frame_tick where counter==COOLDOWN_FRAMES-1: the counter clears and the state goes to ST_ACTIVE.
- Player throw request: rising edge of p_throw, edge-detected internally. Holding the button does not repeat the throw. An edge seen in ST_COOLDOWN is discarded.
- Auto throw request: the auto-throw counter counts frame_ticks whenever auto_mode=1 and game_en=1. When it reaches AUTO_THROW_FRAMES-1 it wraps to 0 and issues a request. The request is honoured only in ST_ACTIVE.
- Movement in ST_ACTIVE and ST_COOLDOWN, auto_mode=0:
  - left = p_left & ~p_right
  - right = p_right & ~p_left
  - both buttons pressed -> both outputs 0
- Movement in ST_ACTIVE and ST_COOLDOWN, auto_mode=1:
  - Patrol direction flips to left when kong_xpos >= AUTO_XMAX.
  - Patrol direction flips to right when kong_xpos <= AUTO_XMIN.
  - left/right follow the patrol direction, exactly one high.
  - Player inputs are ignored.
- auto_mode change mid-game: takes effect on the next cycle, with no state change. The auto-throw counter clears when auto_mode=0.
- Simultaneous throw request and game_en falling: game_en wins and the state goes to ST_IDLE.
- left, right and animation are never high together. barrel_spawn is high only on the ST_WINDUP -> ST_COOLDOWN transition cycle.
- Counters are 8 bits wide. Parameters must satisfy value <= 255.

Test Plan:
- Reset: hold rst=0 with random inputs -> left, right, animation, barrel_spawn and throw_busy all 0. Release rst with game_en=1 -> ST_ACTIVE one cycle later.
- Player move, auto_mode=0: p_left=1 -> left=1 next cycle. Then p_right=1 as well -> left=right=0. Release p_left -> right=1.
- Throw sequence with WINDUP_FRAMES=2, COOLDOWN_FRAMES=3:
  - p_throw pulse -> animation=1 and left=right=0 while p_left is held.
  - On the 2nd frame_tick -> barrel_spawn high for exactly 1 cycle and animation drops.
  - A p_throw edge during the next 3 ticks -> dropped (no spawn).
  - After the 3rd tick -> a new throw is accepted.
- Throw held: p_throw held high for 10 frames -> exactly one barrel_spawn.
- Auto patrol with AUTO_XMIN=16, AUTO_XMAX=560:
  - kong_xpos=300 -> right=1.
  - kong_xpos=560 -> left=1 next cycle.
  - kong_xpos=16 -> right=1.
  - With AUTO_THROW_FRAMES=4 -> a windup starts every 4 ticks when not in cooldown.
- Abort: game_en dropped during ST_WINDUP -> no barrel_spawn, all outputs 0 next cycle. game_en restored -> ST_ACTIVE with counters at 0.
